fea_frame_feeder: RTL and testbench
===================================

Name: fea_frame_feeder

Overview:
- Raster-order pixel source for the feature line-buffer chain.
- Reads a stored ROW x COL frame from a 1-cycle-latency BRAM and emits a din/in_valid stream with downstream backpressure.
- After the frame, appends FLUSH_ROWS padding rows so the last frame rows propagate through the 11-tap buffer chain.
- Drives the buffer chain's active-low enable so every frame starts from clean counters.

Parameters:
- WIDTH, 8, pixel width.
- ROW, 240, frame rows.
- COL, 376, frame columns.
- FLUSH_ROWS, 10, padding rows appended after the frame; 0 is legal and means no flush.
- ADDR_W, 17, BRAM address width; must satisfy 2^ADDR_W >= ROW*COL.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse the cycle after the last stream transfer.
- mem_rd  out  1  BRAM read strobe.
- mem_addr  out  ADDR_W  BRAM address, row*COL+col.
- mem_data  in  WIDTH  BRAM read data, valid exactly 1 cycle after mem_rd.
- out_ready  in  1  downstream may accept.
- out_valid  out  1  dout is valid; this drives in_valid of the buffer chain.
- dout  out  WIDTH  pixel; this drives din of the buffer chain.
- buf_en  out  1  active-low clear for the buffer chain; low in IDLE/DONE, high in FEED/FLUSH.
- out_row  out  9  row index of the current dout, 0..ROW+FLUSH_ROWS-1.
- out_col  out  9  column index of the current dout, 0..COL-1.

Behaviour:
- Reset values: all outputs 0 (busy, done, mem_rd, mem_addr, out_valid, dout, buf_en, out_row, out_col); FSM goes to IDLE; the skid buffer is emptied.
- FSM states: IDLE, ARM, FEED, FLUSH, DRAIN, DONE.
  - IDLE: start=1 -> ARM.
  - ARM: lasts 1 cycle; buf_en rises; counters are cleared.
  - FEED: issues reads for row 0..ROW-1, col 0..COL-1. After the read for (ROW-1, COL-1) is issued -> FLUSH, or -> DRAIN if FLUSH_ROWS=0.
  - FLUSH: generates FLUSH_ROWS*COL padding pixels. After the last one is issued -> DRAIN.
  - DRAIN: waits until the skid buffer and in-flight read are empty and the final transfer has happened -> DONE.
  - DONE: lasts 1 cycle; done=1, busy=0, buf_en=0 -> IDLE.
- Handshake: a transfer occurs when out_valid && out_ready.
  - out_valid, once high, stays high and dout, out_row and out_col stay stable until the transfer.
  - out_valid never depends combinationally on out_ready.
- Read pacing: 2-entry skid FIFO (output register plus 1 spare).
  - A read or padding pixel is issued only when entries + in_flight < 2, counting a transfer in the same cycle as a freed slot.
  - With out_ready held high, throughput is 1 pixel/clk after a 2-cycle initial latency from entering FEED to the first out_valid.
- Counters:
  - Issue column counter wraps at COL-1 -> 0 and increments the issue row.
  - The row index spans 0..ROW+FLUSH_ROWS-1.
  - out_row/out_col travel with the data through the skid FIFO.
- Address: mem_addr = row*COL+col, computed incrementally (+1 per read, no multiplier). Width is truncated to ADDR_W.
- Padding pixels are 0 when FEA_FEEDER_REPLICATE_EN is undefined.
- Boundaries:
  - start while busy is ignored.
  - start in the DONE cycle is ignored.
  - A start that arrives together with rst is lost.
  - out_ready held low indefinitely: at most 2 pixels are outstanding and no reads are issued.
  - rst mid-frame: immediate return to IDLE, buf_en=0, no done pulse.

Optional Feature:
- Macro: FEA_FEEDER_REPLICATE_EN.
  - Defined: FLUSH pixels are real BRAM reads of the last frame row, addr = (ROW-1)*COL+col, with the same latency and pacing as FEED.
  - Undefined: FLUSH issues no mem_rd; padding pixels are constant 0 and enter the skid FIFO directly.
- Stream length and timing of the final transfer are identical in both builds.

Decomposition:
- Shared package fea_pkg holds:
  - localparams for the default ROW, COL and WIDTH;
  - the state enum type feeder_state_t;
  - the function addr_bits(ROW*COL).
- Sub-module fea_skid2: 2-entry valid/ready skid FIFO carrying {row, col, pixel}, with an occupancy output for read credit. The FSM and counters stay in the top level.

Test Plan:
- Basic frame. ROW=4, COL=5, FLUSH_ROWS=2, BRAM preloaded with addr[7:0], out_ready=1, start pulse.
  - Expect 30 transfers.
  - The first 20 carry dout=0..19 with (out_row, out_col) = (0,0)..(3,4).
  - The last 10 carry 0, or 15..19,15..19 with REPLICATE_EN.
  - done 1 cycle after the 30th transfer; buf_en high throughout.
- Backpressure. Same setup, out_ready random at 50%.
  - Identical transfer sequence.
  - dout stays stable while out_valid && !out_ready.
  - Never more than 2 reads outstanding without a transfer.
- Stall. out_ready=0 for 100 cycles after the first out_valid.
  - Exactly 2 mem_rd pulses in total, then resume with no lost or duplicated pixel.
- Reset mid-frame. Assert rst at transfer 7.
  - Next cycle: out_valid=0, buf_en=0, busy=0, no done pulse.
  - A new start replays from pixel 0.
- Start ignored. start pulses at cycles 3 and 15 while busy.
  - Exactly one frame (30 transfers) and one done pulse.
- No flush. FLUSH_ROWS=0: 20 transfers; done 1 cycle after (3,4).

Source files
------------

// File: rtl/fea_frame_feeder_pkg.sv
// Shared types and helpers for the feature frame feeder.
// Holds the default frame geometry, the feeder FSM state type and the
// address-width helper used to size the BRAM address bus.
package fea_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ROW   = 240;
    localparam int DEF_COL   = 376;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } feeder_state_t;

    // Number of address bits needed to cover 'depth' words (at least 1).
    function automatic int addr_bits(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fea_frame_feeder_skid2.sv
// Two-entry valid/ready skid FIFO: an output register plus one spare slot.
// out_valid comes straight from a flop, so it never depends on o_ready
// combinationally. The producer must only push when the occupancy it sees
// (plus anything in flight) leaves room; o_count exposes that occupancy.
module fea_skid2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);

    logic          r_v0;
    logic          r_v1;
    logic [DW-1:0] r_d0;
    logic [DW-1:0] r_d1;
    logic          w_pop;

    assign w_pop   = r_v0 && i_ready;
    assign o_valid = r_v0;
    assign o_data  = r_d0;
    // The spare slot is only ever occupied while the head is occupied.
    assign o_count = {r_v1, r_v0 & ~r_v1};

    // Head/spare update: a pop promotes the spare, a push fills the first free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
        end else if (w_pop) begin
            if (r_v1) begin
                r_d0 <= r_d1;
                r_v1 <= i_push;
                if (i_push) begin
                    r_d1 <= i_data;
                end
            end else begin
                r_v0 <= i_push;
                if (i_push) begin
                    r_d0 <= i_data;
                end
            end
        end else if (!r_v0) begin
            r_v0 <= i_push;
            if (i_push) begin
                r_d0 <= i_data;
            end
        end else if (i_push) begin
            r_v1 <= 1'b1;
            r_d1 <= i_data;
        end
    end

endmodule

// File: rtl/fea_frame_feeder.sv
// Raster-order pixel source for the feature line-buffer chain.
// Reads a ROW x COL frame from a 1-cycle-latency BRAM, streams it with
// valid/ready backpressure through a 2-entry skid FIFO, then appends
// FLUSH_ROWS padding rows so the tail of the frame drains through the
// buffer chain. buf_en (active-low clear) is high only while a frame runs.
// Build option FEA_FEEDER_REPLICATE_EN: padding rows re-read the last frame
// row from BRAM instead of emitting zeros; stream length and timing match.
module fea_frame_feeder
    import fea_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ROW        = DEF_ROW,
    parameter int COL        = DEF_COL,
    parameter int FLUSH_ROWS = 10,
    parameter int ADDR_W     = addr_bits(ROW * COL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  dout,
    output logic              buf_en,
    output logic [8:0]        out_row,
    output logic [8:0]        out_col
);

    localparam int                SKID_W        = 18 + WIDTH;
    localparam logic [8:0]        LAST_COL      = 9'(COL - 1);
    localparam logic [8:0]        LAST_FEED_ROW = 9'(ROW - 1);
    localparam logic [8:0]        LAST_ROW      = 9'(ROW + FLUSH_ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROW - 1) * COL);
    localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);

    feeder_state_t r_state;
    feeder_state_t w_state_nx;

    logic [8:0]        r_row;
    logic [8:0]        r_col;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend;
    logic [8:0]        r_pend_row;
    logic [8:0]        r_pend_col;

    logic [1:0]        w_cnt;
    logic              w_pop;
    logic [2:0]        w_slots;
    logic              w_issue;
    logic              w_last_feed;
    logic              w_last_flush;
    logic              w_drain_empty;
    logic [WIDTH-1:0]  w_pix;
    logic [SKID_W-1:0] w_skid_in;
    logic [SKID_W-1:0] w_skid_out;

    // Credit: skid entries plus the in-flight pixel, with a same-cycle
    // transfer already counted as a freed slot.
    assign w_pop     = out_valid && out_ready;
    assign w_slots   = {1'b0, w_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_issue   = ((r_state == S_FEED) || (r_state == S_FLUSH)) && (w_slots < 3'd2);

    assign w_last_feed   = (r_row == LAST_FEED_ROW) && (r_col == LAST_COL);
    assign w_last_flush  = (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_drain_empty = !r_pend && ((w_cnt == 2'd0) || ((w_cnt == 2'd1) && w_pop));

    assign mem_addr = r_addr;

`ifdef FEA_FEEDER_REPLICATE_EN
    // Padding rows are genuine reads of the last frame row.
    assign mem_rd = w_issue;
    assign w_pix  = mem_data;
`else
    logic r_pend_pad;

    // Padding pixels take the same one-cycle slot as a BRAM read so that
    // ordering and final-transfer timing match the replicate build.
    assign mem_rd = w_issue && (r_state == S_FEED);
    assign w_pix  = r_pend_pad ? '0 : mem_data;

    // Marks the in-flight slot as a zero padding pixel rather than BRAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_pad <= 1'b0;
        end else begin
            r_pend_pad <= w_issue && (r_state == S_FLUSH);
        end
    end
`endif

    assign w_skid_in = {r_pend_row, r_pend_col, w_pix};
    assign {out_row, out_col, dout} = w_skid_out;

    fea_skid2 #(
        .DW (SKID_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pend),
        .i_data  (w_skid_in),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (w_skid_out),
        .o_count (w_cnt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and status outputs; start is only honoured in IDLE.
    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        buf_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_ARM;
                end
            end
            S_ARM: begin
                busy       = 1'b1;
                buf_en     = 1'b1;
                w_state_nx = S_FEED;
            end
            S_FEED: begin
                busy   = 1'b1;
                buf_en = 1'b1;
                if (w_issue && w_last_feed) begin
                    w_state_nx = (FLUSH_ROWS > 0) ? S_FLUSH : S_DRAIN;
                end
            end
            S_FLUSH: begin
                busy   = 1'b1;
                buf_en = 1'b1;
                if (w_issue && w_last_flush) begin
                    w_state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy   = 1'b1;
                buf_en = 1'b1;
                if (w_drain_empty) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Issue counters and in-flight slot; the address advances by one per
    // pixel and snaps back to the last frame row base for every padding row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_addr     <= '0;
            r_pend     <= 1'b0;
            r_pend_row <= '0;
            r_pend_col <= '0;
        end else begin
            r_pend <= w_issue;
            if (r_state == S_ARM) begin
                r_row  <= '0;
                r_col  <= '0;
                r_addr <= '0;
            end else if (w_issue) begin
                r_pend_row <= r_row;
                r_pend_col <= r_col;
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + 9'd1;
                    if ((r_state == S_FLUSH) || w_last_feed) begin
                        r_addr <= LAST_ROW_BASE;
                    end else begin
                        r_addr <= r_addr + ADDR_ONE;
                    end
                end else begin
                    r_col  <= r_col + 9'd1;
                    r_addr <= r_addr + ADDR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fea_frame_feeder.sv
// Directed bench for fea_frame_feeder: two small instances (with and without
// padding rows), each with its own 1-cycle BRAM model holding addr[7:0].
module tb_fea_frame_feeder;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int C  = 5;
    localparam int FL = 2;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    logic          a_start, a_busy, a_done, a_rd, a_valid, a_buf_en;
    logic [AW-1:0] a_addr;
    logic [W-1:0]  a_mdata = '0;
    logic [W-1:0]  a_dout;
    logic [8:0]    a_row, a_col;

    logic          b_start, b_busy, b_done, b_rd, b_valid, b_buf_en;
    logic [AW-1:0] b_addr;
    logic [W-1:0]  b_mdata = '0;
    logic [W-1:0]  b_dout;
    logic [8:0]    b_row, b_col;

    assign a_start = start & ~sel;
    assign b_start = start & sel;

    fea_frame_feeder #(.WIDTH(W), .ROW(R), .COL(C), .FLUSH_ROWS(FL), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .mem_rd(a_rd), .mem_addr(a_addr), .mem_data(a_mdata), .out_ready(ready),
        .out_valid(a_valid), .dout(a_dout), .buf_en(a_buf_en),
        .out_row(a_row), .out_col(a_col)
    );

    fea_frame_feeder #(.WIDTH(W), .ROW(R), .COL(C), .FLUSH_ROWS(0), .ADDR_W(AW)) dut0 (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_rd(b_rd), .mem_addr(b_addr), .mem_data(b_mdata), .out_ready(ready),
        .out_valid(b_valid), .dout(b_dout), .buf_en(b_buf_en),
        .out_row(b_row), .out_col(b_col)
    );

    // BRAM models: word at address a holds a[7:0], one cycle of read latency.
    always @(posedge clk) begin
        if (a_rd) a_mdata <= a_addr;
        if (b_rd) b_mdata <= b_addr;
    end

    logic          o_busy, o_done, o_rd, o_valid, o_buf_en;
    logic [AW-1:0] o_addr;
    logic [W-1:0]  o_dout;
    logic [8:0]    o_row, o_col;

    assign o_busy   = sel ? b_busy   : a_busy;
    assign o_done   = sel ? b_done   : a_done;
    assign o_rd     = sel ? b_rd     : a_rd;
    assign o_valid  = sel ? b_valid  : a_valid;
    assign o_buf_en = sel ? b_buf_en : a_buf_en;
    assign o_addr   = sel ? b_addr   : a_addr;
    assign o_dout   = sel ? b_dout   : a_dout;
    assign o_row    = sel ? b_row    : a_row;
    assign o_col    = sel ? b_col    : a_col;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] q[$];

`ifdef FEA_FEEDER_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected BRAM address of the k-th read of a frame.
    function automatic logic [31:0] exp_addr(input int k);
        if (k < R * C) return 32'(k);
        return 32'((R - 1) * C + (k - R * C) % C);
    endfunction

    // Scoreboard fill: {row, col, pixel} for every pixel of one frame.
    task automatic fill(input int n);
        int row, col, pix;
        q.delete();
        for (int k = 0; k < n; k++) begin
            row = k / C;
            col = k % C;
            if (k < R * C)  pix = k;
            else if (REPL)  pix = (R - 1) * C + col;
            else            pix = 0;
            q.push_back({6'd0, 9'(row), 9'(col), 8'(pix)});
        end
    endtask

    // mode 0: ready=1, mode 1: random ready, mode 2: 100-cycle stall after first valid.
    // rst_at > 0: reset after that many transfers. ign: extra start pulses at cycles 3 and 15.
    task automatic run_frame(input int mode, input int rst_at, input bit ign);
        int  n_exp, n_rd, n_xfer, last_xfer, first_valid, n_done, rd_exp;
        bit  over, stop, exp_done;
        n_exp       = sel ? R * C : (R + FL) * C;
        rd_exp      = (sel || !REPL) ? R * C : (R + FL) * C;
        n_rd        = 0;
        n_xfer      = 0;
        last_xfer   = -10;
        first_valid = -1;
        n_done      = 0;
        over        = 1'b0;
        stop        = 1'b0;
        fill(n_exp);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 1500 && !stop; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (o_valid && first_valid < 0) begin
                first_valid = cyc;
                if (mode == 0) chk(32'(cyc), 32'd3, "first_valid_latency");
            end
            start = ign && (cyc == 3 || cyc == 15);
            if (mode == 0)      ready = 1'b1;
            else if (mode == 1) ready = 1'($urandom_range(0, 1));
            else                ready = (first_valid < 0) || (cyc >= first_valid + 100);
            #1;
            exp_done = (n_xfer == n_exp) && (last_xfer == cyc - 1);
            if (exp_done) over = 1'b1;
            chk(32'(o_done), 32'(exp_done), "done");
            chk(32'(o_busy), 32'(!over), "busy");
            chk(32'(o_buf_en), 32'(!over), "buf_en");
            if (o_done) n_done++;
            if (o_rd) begin
                chk(32'(o_addr), exp_addr(n_rd), "mem_addr");
                n_rd++;
            end
            if (o_valid) begin
                if (q.size() == 0) chk(32'd1, 32'd0, "extra_pixel");
                else chk({6'd0, o_row, o_col, o_dout}, q[0], "pixel");
                if (ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    n_xfer++;
                    last_xfer = cyc;
                end
            end
            chk(32'(n_rd - n_xfer <= 2), 32'd1, "outstanding");
            if (mode == 2 && first_valid >= 0 && cyc == first_valid + 99)
                chk(32'(n_rd), 32'd2, "stall_reads");
            if (rst_at > 0 && n_xfer == rst_at) stop = 1'b1;
            if (over && cyc >= last_xfer + 6) stop = 1'b1;
        end
        start = 1'b0;
        if (!stop) chk(32'd0, 32'd1, "timeout");
        if (rst_at > 0) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk(32'(o_valid), 32'd0, "rst_out_valid");
            chk(32'(o_buf_en), 32'd0, "rst_buf_en");
            chk(32'(o_busy), 32'd0, "rst_busy");
            for (int i = 0; i < 5; i++) begin
                chk(32'(o_done), 32'd0, "rst_no_done");
                @(negedge clk);
                #1;
            end
        end else begin
            chk(32'(n_xfer), 32'(n_exp), "transfer_count");
            chk(32'(n_done), 32'd1, "done_count");
            chk(32'(n_rd), 32'(rd_exp), "read_count");
        end
        ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk(32'({a_busy, a_done, a_rd, a_valid, a_buf_en}), 32'd0, "reset_ctrl_a");
        chk({6'd0, a_row, a_col, a_dout}, 32'd0, "reset_data_a");
        chk(32'(a_addr), 32'd0, "reset_addr_a");
        chk(32'({b_busy, b_done, b_rd, b_valid, b_buf_en}), 32'd0, "reset_ctrl_b");
        chk({6'd0, b_row, b_col, b_dout}, 32'd0, "reset_data_b");
        rst = 1'b0;

        sel = 1'b0;
        run_frame(0, -1, 1'b0);
        run_frame(1, -1, 1'b0);
        run_frame(2, -1, 1'b0);
        run_frame(0, 7, 1'b0);
        run_frame(0, -1, 1'b0);

        // A start coinciding with reset must be lost.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk(32'(o_busy), 32'd0, "start_with_rst");

        run_frame(0, -1, 1'b1);

        sel = 1'b1;
        run_frame(0, -1, 1'b0);
        run_frame(1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
